// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter between functional-unit results and
// the CDB / ROB completion ports.
//   Each source owns a one-entry hold register. Up to N held results are
//   broadcast per cycle. The scan starts at rr_ptr and wraps round-robin.
//   Ports:
//     clock, reset                 clock, synchronous active-high reset
//     squash                       drop every held result and any incoming one
//     src_valid/prn/value/robn     per-source result inputs
//     src_ready                    hold slot can take a result this cycle
//     cdb_valid/prn/value/robn     N broadcast slots; unused slots are all-zero
//     grant_cnt                    number of occupied broadcast slots

// cdb_hold_slot: one-entry result register for a single source.
//   load  : capture din. A load wins over clear, so a granted slot can be
//           refilled at the same edge.
//   clear : the entry was granted this cycle.
//   squash: flush. It overrides both load and clear.
module cdb_hold_slot #(
  parameter int PRN_W  = 6,
  parameter int DATA_W = 32,
  parameter int ROBN_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  logic              load,
  input  logic              clear,
  input  logic [PRN_W-1:0]  din_prn,
  input  logic [DATA_W-1:0] din_value,
  input  logic [ROBN_W-1:0] din_robn,
  output logic              valid,
  output logic [PRN_W-1:0]  prn,
  output logic [DATA_W-1:0] value,
  output logic [ROBN_W-1:0] robn
);
  logic              valid_d, valid_q;
  logic [PRN_W-1:0]  prn_d, prn_q;
  logic [DATA_W-1:0] value_d, value_q;
  logic [ROBN_W-1:0] robn_d, robn_q;

  always_comb begin
    valid_d = valid_q;
    prn_d   = prn_q;
    value_d = value_q;
    robn_d  = robn_q;
    if (squash)     valid_d = 1'b0;
    else if (load)  valid_d = 1'b1;
    else if (clear) valid_d = 1'b0;
    if (load && !squash) begin
      prn_d   = din_prn;
      value_d = din_value;
      robn_d  = din_robn;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      prn_q   <= '0;
      value_q <= '0;
      robn_q  <= '0;
    end else begin
      valid_q <= valid_d;
      prn_q   <= prn_d;
      value_q <= value_d;
      robn_q  <= robn_d;
    end
  end

  assign valid = valid_q;
  assign prn   = prn_q;
  assign value = value_q;
  assign robn  = robn_q;
endmodule

module cdb_arbiter #(
  parameter int N       = 2,
  parameter int NUM_SRC = 8,
  parameter int PRN_W   = 6,
  parameter int DATA_W  = 32,
  parameter int ROBN_W  = 5,
  localparam int CNT_W  = $clog2(N + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC-1:0][PRN_W-1:0]    src_prn,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]   src_value,
  input  logic [NUM_SRC-1:0][ROBN_W-1:0]   src_robn,
  output logic [NUM_SRC-1:0]               src_ready,
  output logic [N-1:0]                     cdb_valid,
  output logic [N-1:0][PRN_W-1:0]          cdb_prn,
  output logic [N-1:0][DATA_W-1:0]         cdb_value,
  output logic [N-1:0][ROBN_W-1:0]         cdb_robn,
  output logic [CNT_W-1:0]                 grant_cnt
);
  localparam int PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int RANK_W = $clog2(NUM_SRC + 1);

  logic [NUM_SRC-1:0]               hold_vld, granted, accept;
  logic [NUM_SRC-1:0][PRN_W-1:0]    hold_prn;
  logic [NUM_SRC-1:0][DATA_W-1:0]   hold_value;
  logic [NUM_SRC-1:0][ROBN_W-1:0]   hold_robn;
  logic [NUM_SRC-1:0][PTR_W-1:0]    pos;
  logic [NUM_SRC-1:0][RANK_W-1:0]   rank;
  logic [PTR_W-1:0]                 rr_ptr_d, rr_ptr_q;
  logic [PTR_W-1:0]                 last_pos;
  int                               last_src;

  assign src_ready = ~hold_vld | granted;
  assign accept    = src_valid & src_ready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    cdb_hold_slot #(.PRN_W(PRN_W), .DATA_W(DATA_W), .ROBN_W(ROBN_W)) u_slot (
      .clock     (clock),
      .reset     (reset),
      .squash    (squash),
      .load      (accept[g]),
      .clear     (granted[g]),
      .din_prn   (src_prn[g]),
      .din_value (src_value[g]),
      .din_robn  (src_robn[g]),
      .valid     (hold_vld[g]),
      .prn       (hold_prn[g]),
      .value     (hold_value[g]),
      .robn      (hold_robn[g])
    );
  end

  // Each source's scan position relative to rr_ptr. Its rank is the number
  // of held entries scanned before it, so sources with rank < N win, and a
  // winner's rank is its CDB slot. All indexing stays on constant loop indices.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      int d;
      d = s - int'(rr_ptr_q);
      if (d < 0) d = d + NUM_SRC;
      pos[s] = PTR_W'(d);
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      rank[s] = '0;
      for (int t = 0; t < NUM_SRC; t++)
        if (hold_vld[t] && (pos[t] < pos[s])) rank[s] = rank[s] + RANK_W'(1);
      granted[s] = hold_vld[s] && (int'(rank[s]) < N);
    end
  end

  always_comb begin
    cdb_valid = '0;
    cdb_prn   = '0;
    cdb_value = '0;
    cdb_robn  = '0;
    grant_cnt = '0;
    last_pos  = '0;
    last_src  = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (granted[s]) begin
        grant_cnt = grant_cnt + CNT_W'(1);
        if (pos[s] >= last_pos) begin
          last_pos = pos[s];
          last_src = s;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (granted[s] && (int'(rank[s]) == k)) begin
          cdb_valid[k] = 1'b1;
          cdb_prn[k]   = hold_prn[s];
          cdb_value[k] = hold_value[s];
          cdb_robn[k]  = hold_robn[s];
        end
      end
    end
  end

  // Next scan begins just past the last winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (squash)
      rr_ptr_d = '0;
    else if (grant_cnt != '0)
      rr_ptr_d = (last_src == NUM_SRC - 1) ? '0 : PTR_W'(last_src + 1);
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N = 2, NUM_SRC = 8, PRN_W = 6, DATA_W = 32, ROBN_W = 5, CNT_W = 2;

  logic                           clock = 1'b0;
  logic                           reset, squash;
  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0][PRN_W-1:0]  src_prn;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_value;
  logic [NUM_SRC-1:0][ROBN_W-1:0] src_robn;
  logic [NUM_SRC-1:0]             src_ready;
  logic [N-1:0]                   cdb_valid;
  logic [N-1:0][PRN_W-1:0]        cdb_prn;
  logic [N-1:0][DATA_W-1:0]       cdb_value;
  logic [N-1:0][ROBN_W-1:0]       cdb_robn;
  logic [CNT_W-1:0]               grant_cnt;

  int checks = 0, errors = 0;

  cdb_arbiter #(.N(N), .NUM_SRC(NUM_SRC), .PRN_W(PRN_W), .DATA_W(DATA_W), .ROBN_W(ROBN_W)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .src_valid(src_valid), .src_prn(src_prn), .src_value(src_value), .src_robn(src_robn),
    .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_prn(cdb_prn),
    .cdb_value(cdb_value), .cdb_robn(cdb_robn), .grant_cnt(grant_cnt)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  // Source s carries prn s+1, value 0x1000+s, robn s+8.
  task automatic set_src_data();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_prn[i]   = PRN_W'(i + 1);
      src_value[i] = 32'h1000 + i;
      src_robn[i]  = ROBN_W'(i + 8);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; squash = 1'b0; src_valid = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", cdb_valid); end
    checks++; if (grant_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", grant_cnt); end
    checks++; if (src_ready !== 8'hFF) begin errors++; $display("FAIL reset_ready: got %h expected ff", src_ready); end
    checks++; if (cdb_prn !== '0 || cdb_value !== '0 || cdb_robn !== '0) begin
      errors++; $display("FAIL reset_fields: got prn %h value %h robn %h expected all 0", cdb_prn, cdb_value, cdb_robn);
    end
  endtask

  task automatic test_single();
    apply_reset();
    src_valid = 8'h01; src_prn[0] = 6'd3; src_value[0] = 32'd7; src_robn[0] = 5'd4;
    step();
    src_valid = '0;
    checks++; if (cdb_valid !== 2'b01) begin errors++; $display("FAIL single_valid: got %b expected 01", cdb_valid); end
    checks++; if (cdb_prn[0] !== 6'd3 || cdb_value[0] !== 32'd7 || cdb_robn[0] !== 5'd4) begin
      errors++; $display("FAIL single_fields: got prn %0d value %0d robn %0d expected 3 7 4", cdb_prn[0], cdb_value[0], cdb_robn[0]);
    end
    checks++; if (grant_cnt !== 2'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", grant_cnt); end
    checks++; if (cdb_prn[1] !== 6'd0 || cdb_value[1] !== 32'd0 || cdb_robn[1] !== 5'd0) begin
      errors++; $display("FAIL single_unused_slot: got prn %0d value %0d robn %0d expected 0 0 0", cdb_prn[1], cdb_value[1], cdb_robn[1]);
    end
    step();
    checks++; if (cdb_valid !== 2'b00 || grant_cnt !== 2'd0) begin
      errors++; $display("FAIL single_drain: got valid %b cnt %0d expected 00 0", cdb_valid, grant_cnt);
    end
    set_src_data();
  endtask

  task automatic test_prn_zero();
    apply_reset();
    src_valid = 8'h10; src_prn[4] = 6'd0;
    step();
    src_valid = '0;
    checks++; if (cdb_valid !== 2'b01 || cdb_prn[0] !== 6'd0 || cdb_robn[0] !== 5'd12) begin
      errors++; $display("FAIL prn_zero: got valid %b prn %0d robn %0d expected 01 0 12", cdb_valid, cdb_prn[0], cdb_robn[0]);
    end
    set_src_data();
  endtask

  task automatic test_three();
    apply_reset();
    src_valid = 8'h07;
    step();
    src_valid = '0;
    checks++; if (cdb_valid !== 2'b11 || cdb_prn[0] !== 6'd1 || cdb_prn[1] !== 6'd2) begin
      errors++; $display("FAIL three_first: got valid %b prn %0d,%0d expected 11 1,2", cdb_valid, cdb_prn[0], cdb_prn[1]);
    end
    checks++; if (src_ready !== 8'hFB) begin errors++; $display("FAIL three_ready0: got %h expected fb", src_ready); end
    step();
    checks++; if (cdb_valid !== 2'b01 || cdb_prn[0] !== 6'd3 || cdb_value[0] !== 32'h1002) begin
      errors++; $display("FAIL three_second: got valid %b prn %0d value %h expected 01 3 1002", cdb_valid, cdb_prn[0], cdb_value[0]);
    end
    checks++; if (src_ready !== 8'hFF) begin errors++; $display("FAIL three_ready1: got %h expected ff", src_ready); end
  endtask

  task automatic test_all_held();
    logic [7:0] held;
    apply_reset();
    src_valid = 8'hFF;
    step();
    src_valid = '0;
    for (int c = 0; c < 4; c++) begin
      held = 8'hFF;
      held = held << (2 * c + 2);
      checks++; if (cdb_valid !== 2'b11 || grant_cnt !== 2'd2 ||
                    cdb_prn[0] !== PRN_W'(2 * c + 1) || cdb_prn[1] !== PRN_W'(2 * c + 2)) begin
        errors++; $display("FAIL all_held_c%0d: got valid %b cnt %0d prn %0d,%0d expected 11 2 %0d,%0d",
                           c, cdb_valid, grant_cnt, cdb_prn[0], cdb_prn[1], 2 * c + 1, 2 * c + 2);
      end
      checks++; if (src_ready !== ~held) begin errors++; $display("FAIL all_held_ready_c%0d: got %h expected %h", c, src_ready, ~held); end
      step();
    end
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL all_held_idle: got %b expected 00", cdb_valid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    src_valid = 8'h03; src_value[0] = 32'd100; src_value[1] = 32'd200;
    for (int c = 0; c < 5; c++) begin
      checks++; if (src_ready !== 8'hFF) begin errors++; $display("FAIL b2b_ready_c%0d: got %h expected ff", c, src_ready); end
      step();
      checks++; if (cdb_valid !== 2'b11 || grant_cnt !== 2'd2 ||
                    cdb_value[0] !== 32'(100 + c) || cdb_value[1] !== 32'(200 + c)) begin
        errors++; $display("FAIL b2b_c%0d: got valid %b cnt %0d value %0d,%0d expected 11 2 %0d,%0d",
                           c, cdb_valid, grant_cnt, cdb_value[0], cdb_value[1], 100 + c, 200 + c);
      end
      src_value[0] = 32'(101 + c); src_value[1] = 32'(201 + c);
      if (c == 4) src_valid = '0;
    end
    step();
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b expected 00", cdb_valid); end
    set_src_data();
  endtask

  task automatic test_squash();
    apply_reset();
    src_valid = 8'h2B;
    step();
    // 0 and 1 are on the bus now; 3 and 5 stay held.
    src_valid = 8'h40; squash = 1'b1;
    checks++; if (cdb_valid !== 2'b11 || cdb_prn[0] !== 6'd1 || cdb_prn[1] !== 6'd2) begin
      errors++; $display("FAIL squash_cycle_out: got valid %b prn %0d,%0d expected 11 1,2", cdb_valid, cdb_prn[0], cdb_prn[1]);
    end
    checks++; if (src_ready !== 8'hD7) begin errors++; $display("FAIL squash_cycle_ready: got %h expected d7", src_ready); end
    step();
    src_valid = '0; squash = 1'b0;
    checks++; if (cdb_valid !== 2'b00 || grant_cnt !== 2'd0 || src_ready !== 8'hFF) begin
      errors++; $display("FAIL squash_after: got valid %b cnt %0d ready %h expected 00 0 ff", cdb_valid, grant_cnt, src_ready);
    end
    step();
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL squash_no_src6: got %b expected 00", cdb_valid); end
    // The pointer restarted at 0, so 1 and 2 beat 7.
    src_valid = 8'h86;
    step();
    src_valid = '0;
    checks++; if (cdb_prn[0] !== 6'd2 || cdb_prn[1] !== 6'd3) begin
      errors++; $display("FAIL squash_rr: got prn %0d,%0d expected 2,3", cdb_prn[0], cdb_prn[1]);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    src_valid = 8'h3C;
    step();
    src_valid = '0;
    checks++; if (cdb_prn[0] !== 6'd3 || cdb_prn[1] !== 6'd4) begin
      errors++; $display("FAIL midrst_pre: got prn %0d,%0d expected 3,4", cdb_prn[0], cdb_prn[1]);
    end
    reset = 1'b1; squash = 1'b1; src_valid = 8'h01;
    step();
    reset = 1'b0; squash = 1'b0; src_valid = '0;
    checks++; if (cdb_valid !== 2'b00 || grant_cnt !== 2'd0 || src_ready !== 8'hFF ||
                  cdb_prn !== '0 || cdb_value !== '0 || cdb_robn !== '0) begin
      errors++; $display("FAIL midrst_clear: got valid %b cnt %0d ready %h prn %h expected 00 0 ff 0", cdb_valid, grant_cnt, src_ready, cdb_prn);
    end
    src_valid = 8'h81;
    step();
    src_valid = '0;
    checks++; if (cdb_prn[0] !== 6'd1 || cdb_prn[1] !== 6'd8) begin
      errors++; $display("FAIL midrst_rr: got prn %0d,%0d expected 1,8", cdb_prn[0], cdb_prn[1]);
    end
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; src_valid = '0;
    set_src_data();
    test_reset();
    test_single();
    test_prn_zero();
    test_three();
    test_all_held();
    test_back_to_back();
    test_squash();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
